// File: rtl/button_debounce.sv
// Button conditioning: 2-flop synchronizer, per-button debounce counter, sticky press events.
// Optional sticky release events are enabled by defining BTN_RELEASE_EVT_EN.
module button_debounce #(
   parameter int unsigned NUM_BTN         = 8,
   parameter int unsigned CNT_WIDTH       = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               evt_clr,
   input  logic [NUM_BTN-1:0] evt_clr_mask,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] press_pulse
`ifdef BTN_RELEASE_EVT_EN
   ,
   output logic [NUM_BTN-1:0] btn_release
`endif
);

   localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0]                sync1_q, sync2_q;
   logic [NUM_BTN-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_BTN-1:0]                level_q, level_d;
   logic [NUM_BTN-1:0]                press_q, press_d;
   logic [NUM_BTN-1:0]                pulse_q, pulse_d;
   logic [NUM_BTN-1:0]                accept;
   logic [NUM_BTN-1:0]                rise;
   logic [NUM_BTN-1:0]                clr_bits;

   // A button's level flips only after sync2 has disagreed with it for DEBOUNCE_CYCLES cycles.
   always_comb begin
      accept = '0;
      cnt_d  = cnt_q;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            cnt_d[i]  = '0;
            accept[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      level_d  = level_q ^ accept;
      rise     = accept & sync2_q;
      clr_bits = evt_clr ? evt_clr_mask : '0;
      // Set has priority over a coincident clear so a new press is never lost.
      press_d  = (press_q & ~clr_bits) | rise;
      pulse_d  = rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         press_q <= '0;
         pulse_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         pulse_q <= pulse_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign press_pulse = pulse_q;

`ifdef BTN_RELEASE_EVT_EN
   logic [NUM_BTN-1:0] fall;
   logic [NUM_BTN-1:0] release_q, release_d;

   always_comb begin
      fall      = accept & ~sync2_q;
      release_d = (release_q & ~clr_bits) | fall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         release_q <= '0;
      end else begin
         release_q <= release_d;
      end
   end

   assign btn_release = release_q;
`else
   // Release edges only move btn_level; no event is recorded.
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4 (acceptance 6 cycles after an edge).
// Define BTN_RELEASE_EVT_EN to also exercise the release-event flags.
module tb_button_debounce;

   localparam int unsigned NB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_raw;
   logic          evt_clr;
   logic [NB-1:0] evt_clr_mask;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] press_pulse;
`ifdef BTN_RELEASE_EVT_EN
   logic [NB-1:0] btn_release;
`endif

   int checks = 0;
   int errors = 0;

   button_debounce #(
      .NUM_BTN        (NB),
      .CNT_WIDTH      (3),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .evt_clr     (evt_clr),
      .evt_clr_mask(evt_clr_mask),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
`ifdef BTN_RELEASE_EVT_EN
      .press_pulse (press_pulse),
      .btn_release (btn_release)
`else
      .press_pulse (press_pulse)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      btn_raw      = 8'hFF;
      evt_clr      = 1'b0;
      evt_clr_mask = 8'h00;

      // 1. Reset with all buttons held, then release.
      tick(3);
      chk("rst_level", btn_level, 8'h00);
      chk("rst_press", btn_press, 8'h00);
      chk("rst_pulse", press_pulse, 8'h00);
`ifdef BTN_RELEASE_EVT_EN
      chk("rst_release", btn_release, 8'h00);
`endif
      rst_n = 1'b1;
      tick(5);
      chk("held_level_early", btn_level, 8'h00);
      tick(1);
      chk("held_level", btn_level, 8'hFF);
      chk("held_press", btn_press, 8'hFF);
      chk("held_pulse", press_pulse, 8'hFF);
      tick(1);
      chk("held_pulse_end", press_pulse, 8'h00);
      chk("held_press_sticky", btn_press, 8'hFF);

      // 3. Clear-on-read, plus a mask without strobe that must do nothing.
      evt_clr_mask = 8'hFF;
      tick(1);
      chk("mask_no_strobe", btn_press, 8'hFF);
      evt_clr      = 1'b1;
      evt_clr_mask = 8'h7E;
      tick(1);
      evt_clr = 1'b0;
      chk("clr_7e", btn_press, 8'h81);
      evt_clr      = 1'b1;
      evt_clr_mask = 8'h01;
      tick(1);
      evt_clr = 1'b0;
      chk("clr_01", btn_press, 8'h80);

      // Release everything: level falls, press flags untouched.
      btn_raw = 8'h00;
      tick(6);
      chk("rel_level", btn_level, 8'h00);
      chk("rel_press", btn_press, 8'h80);
      chk("rel_pulse", press_pulse, 8'h00);
`ifdef BTN_RELEASE_EVT_EN
      chk("rel_release", btn_release, 8'hFF);
      evt_clr      = 1'b1;
      evt_clr_mask = 8'hFF;
      tick(1);
      evt_clr = 1'b0;
      chk("rel_release_clr", btn_release, 8'h00);
`endif
      evt_clr      = 1'b1;
      evt_clr_mask = 8'hFF;
      tick(1);
      evt_clr = 1'b0;
      chk("clr_all", btn_press, 8'h00);

      // 2. Bounce on bit 0, then hold high.
      btn_raw = 8'h01; tick(1);
      btn_raw = 8'h00; tick(1);
      btn_raw = 8'h01; tick(1);
      btn_raw = 8'h00; tick(1);
      btn_raw = 8'h01;
      tick(5);
      chk("bounce_level_early", btn_level, 8'h00);
      chk("bounce_pulse_early", press_pulse, 8'h00);
      tick(1);
      chk("bounce_level", btn_level, 8'h01);
      chk("bounce_pulse", press_pulse, 8'h01);
      tick(1);
      chk("bounce_pulse_once", press_pulse, 8'h00);
      chk("bounce_press", btn_press, 8'h01);

      // 4. Bit 3 rises in the same cycle a clear of bits 0 and 3 is strobed.
      btn_raw = 8'h09;
      tick(5);
      evt_clr      = 1'b1;
      evt_clr_mask = 8'h09;
      tick(1);
      evt_clr = 1'b0;
      chk("coll_press", btn_press, 8'h08);
      chk("coll_level", btn_level, 8'h09);
      chk("coll_pulse", press_pulse, 8'h08);

      // 5. Bit 5 mid-count when reset hits; everything restarts from scratch.
      btn_raw = 8'h29;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", btn_level, 8'h00);
      chk("async_rst_press", btn_press, 8'h00);
      tick(1);
      rst_n = 1'b1;
      tick(5);
      chk("restart_level_early", btn_level, 8'h00);
      tick(1);
      chk("restart_level", btn_level, 8'h29);
      chk("restart_press", btn_press, 8'h29);
      chk("restart_pulse", press_pulse, 8'h29);

`ifdef BTN_RELEASE_EVT_EN
      // 6. Press and release bit 7.
      btn_raw = 8'hA9;
      tick(6);
      chk("b7_press", btn_press, 8'hA9);
      btn_raw = 8'h29;
      tick(5);
      chk("b7_release_early", btn_release, 8'h00);
      tick(1);
      chk("b7_release", btn_release, 8'h80);
      chk("b7_press_kept", btn_press, 8'hA9);
      chk("b7_level", btn_level, 8'h29);
      evt_clr      = 1'b1;
      evt_clr_mask = 8'h80;
      tick(1);
      evt_clr = 1'b0;
      chk("b7_release_clr", btn_release, 8'h00);
      chk("b7_press_clr", btn_press, 8'h29);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
